// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration chain loader.
// Holds the control state encoding and the tail readback signature update.
package ccff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   localparam int SIG_W = 8;

   // Rotate left by one, folding the returning tail bit into the new LSB.
   function automatic logic [SIG_W-1:0] sig_update(input logic [SIG_W-1:0] sig,
                                                   input logic             din);
      return {sig[SIG_W-2:0], sig[SIG_W-1] ^ din};
   endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Byte stream into the loader plus the serial link to the fabric config chain.
// master = byte source / chain side, slave = the loader itself.
interface ccff_chain_loader_if;

   logic [7:0] cfg_data;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       ccff_head;
   logic       ccff_shift_en;
   logic       ccff_tail;

   modport master (
      output cfg_data, cfg_valid, ccff_tail,
      input  cfg_ready, ccff_head, ccff_shift_en
   );

   modport slave (
      input  cfg_data, cfg_valid, ccff_tail,
      output cfg_ready, ccff_head, ccff_shift_en
   );

endinterface

// File: rtl/ccff_tail_sig.sv
// Rotate-xor accumulator over the bits returning from the chain tail.
// Clear wins over enable so a new load always starts from a zero signature.
module ccff_tail_sig
   import ccff_pkg::*;
(
   input  logic             prog_clk,
   input  logic             pReset_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= sig_update(sig, din);
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises config bytes LSB-first into the head of a CHAIN_LEN-bit config
// flip-flop chain and stops after exactly CHAIN_LEN shifts.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                prog_clk,
   input  logic                pReset_n,
   input  logic                start,
   input  logic                abort,
   ccff_chain_loader_if.slave  bus,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    bit_count,
   output logic [SIG_W-1:0]    tail_sig
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

   state_e     state;
   state_e     state_nxt;
   logic [7:0] sreg;
   logic [3:0] nbits;
   logic [3:0] nbits_load;
   logic       shift;
   logic       accept;
   logic       last_shift;
   logic       begin_load;

   assign busy       = (state == SHIFT);
   assign done       = (state == DONE);
   assign shift      = busy && (nbits != 4'd0);
   assign last_shift = shift && (bit_count == LAST_IDX);
   assign begin_load = start && !abort && (state != SHIFT);
   assign accept     = bus.cfg_valid && bus.cfg_ready;

   // Taking the next byte while its predecessor's last bit shifts keeps the
   // head fed every cycle; the final bit of the chain never asks for more.
   assign bus.cfg_ready     = busy && ((nbits == 4'd0) ||
                                       ((nbits == 4'd1) && (bit_count != LAST_IDX)));
   assign bus.ccff_head     = sreg[0];
   assign bus.ccff_shift_en = shift;

   // Clip the final byte to the bits the chain still needs after this edge.
   always_comb begin : nbits_calc
      int remaining;
      remaining  = CHAIN_LEN - int'(bit_count) - (shift ? 1 : 0);
      nbits_load = (remaining >= 8) ? 4'd8 : 4'(remaining);
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt gets a default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start)      state_nxt = SHIFT;
         SHIFT:   if (last_shift) state_nxt = DONE;
         DONE:    if (start)      state_nxt = SHIFT;
         default:                 state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         sreg      <= '0;
         nbits     <= '0;
         bit_count <= '0;
      end else if (begin_load) begin
         sreg      <= '0;
         nbits     <= '0;
         bit_count <= '0;
      end else begin
         if (shift) begin
            bit_count <= bit_count + CNT_W'(1);
         end
         // A bit on the wire during abort still counts; the byte does not.
         if (abort) begin
            sreg  <= '0;
            nbits <= '0;
         end else if (accept) begin
            sreg  <= bus.cfg_data;
            nbits <= nbits_load;
         end else if (shift) begin
            sreg  <= sreg >> 1;
            nbits <= nbits - 4'd1;
         end
      end
   end

   ccff_tail_sig u_tail_sig (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .clr      (begin_load),
      .en       (shift),
      .din      (bus.ccff_tail),
      .sig      (tail_sig)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 20-bit chain instance and a 1-bit
// chain instance, with hand-computed head bit streams, counts and signatures.
module tb_ccff_chain_loader;

   logic       prog_clk;
   logic       pReset_n;
   logic       start20, abort20, start1, abort1;
   logic       busy20, done20, busy1, done1;
   logic [4:0] bc20;
   logic [0:0] bc1;
   logic [7:0] sig20, sig1;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] bytes [3];
   logic       exp_bits [20];

   ccff_chain_loader_if bus20 ();
   ccff_chain_loader_if bus1 ();

   ccff_chain_loader #(.CHAIN_LEN(20)) dut20 (
      .prog_clk  (prog_clk),
      .pReset_n  (pReset_n),
      .start     (start20),
      .abort     (abort20),
      .bus       (bus20),
      .busy      (busy20),
      .done      (done20),
      .bit_count (bc20),
      .tail_sig  (sig20)
   );

   ccff_chain_loader #(.CHAIN_LEN(1)) dut1 (
      .prog_clk  (prog_clk),
      .pReset_n  (pReset_n),
      .start     (start1),
      .abort     (abort1),
      .bus       (bus1),
      .busy      (busy1),
      .done      (done1),
      .bit_count (bc1),
      .tail_sig  (sig1)
   );

   initial begin
      prog_clk = 1'b0;
      forever #5 prog_clk = ~prog_clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Leaves the bench 1 time unit after a rising edge, where inputs change.
   task automatic next_cycle();
      @(posedge prog_clk);
      #1;
   endtask

   // One load into the 20-bit chain of bytes A5,3C,0F. gap: cycles cfg_valid
   // is withheld when the second byte is due; abort_at / restart_at: bit
   // count at which abort / a stray start is pulsed (-1 = never).
   task automatic run_load(input string tag, input int gap, input int abort_at,
                           input int restart_at, input logic tail_bit,
                           input logic [7:0] exp_sig);
      int  k = 0;
      int  bi = 0;
      int  c = 0;
      int  stall = 0;
      int  cyc = 0;
      bit  first_acc = 0;
      bit  fin = 0;
      bit  aborting;
      start20 = 1'b1;
      abort20 = 1'b0;
      bus20.cfg_valid = 1'b0;
      bus20.cfg_data  = 8'h00;
      bus20.ccff_tail = tail_bit;
      next_cycle();
      start20 = 1'b0;
      while (!fin && cyc < 80) begin
         bus20.cfg_valid = (bi < 3) && !(first_acc && c >= 8 && c < 8 + gap);
         if (bi < 3) bus20.cfg_data = bytes[bi];
         else        bus20.cfg_data = 8'h00;
         aborting = (abort_at >= 0) && (k == abort_at);
         abort20  = aborting;
         start20  = (restart_at >= 0) && (k == restart_at);
         #4;
         if (cyc == 0) begin
            check({tag, "_clr_cnt"}, bc20, 0);
            check({tag, "_clr_sig"}, sig20, 0);
         end
         if (k == 7 || k == 15) check({tag, "_handover_ready"}, bus20.cfg_ready, 1);
         if (k == 19) check({tag, "_last_ready"}, bus20.cfg_ready, 0);
         if (bus20.ccff_shift_en) begin
            if (k < 20) check({tag, "_head"}, bus20.ccff_head, exp_bits[k]);
            else        check({tag, "_overrun"}, k, 19);
            check({tag, "_cnt"}, bc20, k);
            k++;
         end else if (k > 0) begin
            stall++;
            check({tag, "_stall_cnt"}, bc20, k);
         end
         if (aborting) check({tag, "_abort_shift"}, bus20.ccff_shift_en, 1);
         if (bus20.cfg_valid && bus20.cfg_ready) begin
            bi++;
            if (bi == 1) begin
               first_acc = 1;
               c = 0;
            end
         end
         next_cycle();
         if (first_acc) c++;
         cyc++;
         if (aborting || done20) fin = 1;
      end
      bus20.cfg_valid = 1'b0;
      abort20 = 1'b0;
      start20 = 1'b0;
      check({tag, "_finished"}, fin, 1);
      #4;
      if (abort_at >= 0) begin
         check({tag, "_ab_busy"}, busy20, 0);
         check({tag, "_ab_done"}, done20, 0);
         check({tag, "_ab_shift"}, bus20.ccff_shift_en, 0);
         check({tag, "_ab_ready"}, bus20.cfg_ready, 0);
         check({tag, "_ab_cnt"}, bc20, abort_at + 1);
      end else begin
         check({tag, "_done"}, done20, 1);
         check({tag, "_busy"}, busy20, 0);
         check({tag, "_final_cnt"}, bc20, 20);
         check({tag, "_final_shift"}, bus20.ccff_shift_en, 0);
         check({tag, "_final_ready"}, bus20.cfg_ready, 0);
         check({tag, "_shifts"}, k, 20);
         check({tag, "_stalls"}, stall, gap);
         check({tag, "_bytes"}, bi, 3);
         check({tag, "_sig"}, sig20, exp_sig);
      end
      next_cycle();
   endtask

   initial begin
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      bytes[2] = 8'h0F;
      for (int i = 0; i < 20; i++) exp_bits[i] = bytes[i / 8][i % 8];

      pReset_n = 1'b0;
      start20 = 1'b0; abort20 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
      bus20.cfg_valid = 1'b0; bus20.cfg_data = 8'h00; bus20.ccff_tail = 1'b0;
      bus1.cfg_valid  = 1'b0; bus1.cfg_data  = 8'h00; bus1.ccff_tail  = 1'b0;
      #2;
      check("rst_ready", bus20.cfg_ready, 0);
      check("rst_head", bus20.ccff_head, 0);
      check("rst_shift", bus20.ccff_shift_en, 0);
      check("rst_busy", busy20, 0);
      check("rst_done", done20, 0);
      check("rst_cnt", bc20, 0);
      check("rst_sig", sig20, 0);
      check("rst1_ready", bus1.cfg_ready, 0);
      #1;
      pReset_n = 1'b1;
      next_cycle();

      run_load("t1_b2b",   0, -1, -1, 1'b0, 8'h00);
      run_load("t2_gap",   3, -1, -1, 1'b0, 8'h00);
      run_load("t3_tail1", 0, -1, -1, 1'b1, 8'h0F);
      run_load("t3_clear", 0, -1, -1, 1'b0, 8'h00);
      run_load("t4_abort", 0, 11, -1, 1'b0, 8'h00);
      run_load("t4_reload",0, -1, -1, 1'b0, 8'h00);
      run_load("t5_start", 0, -1,  5, 1'b0, 8'h00);

      // Asynchronous reset in the middle of the first byte.
      start20 = 1'b1;
      next_cycle();
      start20 = 1'b0;
      bus20.cfg_valid = 1'b1;
      bus20.cfg_data  = 8'hA5;
      next_cycle();
      bus20.cfg_valid = 1'b0;
      repeat (4) next_cycle();
      check("t5_pre_cnt", bc20, 4);
      #2;
      pReset_n = 1'b0;
      #1;
      check("t5_ready", bus20.cfg_ready, 0);
      check("t5_head", bus20.ccff_head, 0);
      check("t5_shift", bus20.ccff_shift_en, 0);
      check("t5_busy", busy20, 0);
      check("t5_done", done20, 0);
      check("t5_cnt", bc20, 0);
      check("t5_sig", sig20, 0);
      #3;
      pReset_n = 1'b1;
      next_cycle();
      run_load("t5_reload", 0, -1, -1, 1'b0, 8'h00);

      // One-bit chain, byte FF.
      bus1.ccff_tail = 1'b1;
      start1 = 1'b1;
      next_cycle();
      start1 = 1'b0;
      bus1.cfg_valid = 1'b1;
      bus1.cfg_data  = 8'hFF;
      #4;
      check("t6_ready_first", bus1.cfg_ready, 1);
      check("t6_shift_idle", bus1.ccff_shift_en, 0);
      next_cycle();
      #4;
      check("t6_shift", bus1.ccff_shift_en, 1);
      check("t6_head", bus1.ccff_head, 1);
      check("t6_ready_shift", bus1.cfg_ready, 0);
      check("t6_cnt_shift", bc1, 0);
      next_cycle();
      #4;
      check("t6_done", done1, 1);
      check("t6_busy", busy1, 0);
      check("t6_cnt", bc1, 1);
      check("t6_shift_done", bus1.ccff_shift_en, 0);
      check("t6_sig", sig1, 8'h01);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #4;
         check("t6_ready_after", bus1.cfg_ready, 0);
      end
      bus1.cfg_valid = 1'b0;
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
